// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-bank responder.
package i2c_slave_pkg;

  // Protocol phases of the responder.
  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StMack,
    StWait
  } i2c_state_e;

  // Acknowledge bit levels on SDA.
  localparam logic Ack  = 1'b0;
  localparam logic Nack = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser, glitch filter and edge pulses for one open-drain bus line.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_cnt;
  logic            r_filt;
  logic            r_filt_prev;

  // Synchronise the pin; idle bus level is high so reset there to avoid phantom edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_line};
    end
  end

  // Accept a new level only after FILT_LEN consecutive samples disagree with the current one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_filt      <= 1'b1;
      r_filt_prev <= 1'b1;
    end else begin
      r_filt_prev <= r_filt;
      if (r_sync[1] != r_filt) begin
        if (r_cnt == CntW'(FILT_LEN - 1)) begin
          r_filt <= r_sync[1];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_filt;
  assign o_rise  = r_filt & ~r_filt_prev;
  assign o_fall  = ~r_filt & r_filt_prev;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C responder exposing a byte register bank: pointer byte, then data writes with
// auto-increment, or reads starting at the current pointer.
module i2c_slave_regs
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  DEV_ID   = 7'h54,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned FILT_LEN = 4,
  localparam int unsigned PtrW    = $clog2(NUM_REGS)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_oe,
  output logic                  o_wr_vld,
  output logic [PtrW-1:0]       o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_busy,
  output logic [8*NUM_REGS-1:0] o_reg_q
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0]      w_byte;
  logic [PtrW-1:0] w_ptr_inc;

  i2c_state_e      r_state;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_rd_shift;
  logic [PtrW-1:0] r_ptr;
  logic            r_rw;
  logic            r_sda_oe;
  logic            r_wr_vld;
  logic [PtrW-1:0] r_wr_addr;
  logic [7:0]      r_wr_data;
  logic            r_busy;
  logic [7:0]      r_regs [NUM_REGS];

  i2c_line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_scl_filt (
    .i_clk   (i_sys_clk),
    .i_rst   (i_sys_rst),
    .i_line  (i_scl),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_sda_filt (
    .i_clk   (i_sys_clk),
    .i_rst   (i_sys_rst),
    .i_line  (i_sda),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start   = w_sda_fall & w_scl_lvl;
  assign w_stop    = w_sda_rise & w_scl_lvl;
  assign w_byte    = {r_shift[6:0], w_sda_lvl};
  assign w_ptr_inc = r_ptr + PtrW'(1);

  // Protocol FSM: bus conditions first, then bit sampling on SCL rise, SDA updates on SCL fall.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state    <= StIdle;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rd_shift <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_vld   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wr_vld <= 1'b0;
      if (w_start) begin
        // Repeated START keeps busy and the pointer; any partial byte is dropped.
        r_state   <= StAddr;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state   <= StIdle;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          StAddr: begin
            r_shift <= w_byte;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              if (w_byte[7:1] == DEV_ID) begin
                r_state <= StAddrAck;
                r_rw    <= w_byte[0];
                r_busy  <= 1'b1;
              end else begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          StPtr: begin
            r_shift <= w_byte;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              r_ptr     <= w_byte[PtrW-1:0];
              r_state   <= StPtrAck;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          StWdata: begin
            r_shift <= w_byte;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt     <= '0;
              r_regs[r_ptr] <= w_byte;
              r_wr_vld      <= 1'b1;
              r_wr_addr     <= r_ptr;
              r_wr_data     <= w_byte;
              r_ptr         <= w_ptr_inc;
              r_state       <= StWdataAck;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          StRdata: begin
            r_rd_shift <= {r_rd_shift[6:0], 1'b0};
            r_bit_cnt  <= r_bit_cnt + 4'd1;
          end
          StMack: begin
            if (w_sda_lvl == Ack) begin
              // Byte latched now so a later write cannot disturb it mid-shift.
              r_ptr      <= w_ptr_inc;
              r_rd_shift <= r_regs[w_ptr_inc];
              r_bit_cnt  <= '0;
              r_state    <= StRdata;
            end else begin
              r_state <= StWait;
              r_busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          StAddrAck, StPtrAck, StWdataAck: begin
            // First fall drives the ACK, the next one ends the ACK clock.
            if (!r_sda_oe) begin
              r_sda_oe <= ~Ack;
            end else begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= '0;
              if (r_state == StAddrAck) begin
                if (r_rw) begin
                  r_rd_shift <= r_regs[r_ptr];
                  r_sda_oe   <= ~r_regs[r_ptr][7];
                  r_state    <= StRdata;
                end else begin
                  r_state <= StPtr;
                end
              end else begin
                r_state <= StWdata;
              end
            end
          end
          StRdata: begin
            if (r_bit_cnt == 4'd8) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= StMack;
            end else begin
              r_sda_oe <= ~r_rd_shift[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < int'(NUM_REGS); gi++) begin : g_reg_q
    assign o_reg_q[8*gi +: 8] = r_regs[gi];
  end

  assign o_sda_oe  = r_sda_oe;
  assign o_wr_vld  = r_wr_vld;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged master on a wired-AND bus.
module tb_i2c_slave_regs;

  localparam int unsigned NumRegs = 8;
  localparam int unsigned Q       = 16;  // sys_clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        g_scl = 1'b0;
  logic        g_sda = 1'b0;
  logic        w_scl;
  logic        w_sda;
  logic        sda_oe;
  logic        wr_vld;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic [63:0] reg_q;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [2:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic [7:0] m_regs [NumRegs];

  assign w_scl = m_scl & ~g_scl;
  assign w_sda = m_sda & ~sda_oe & ~g_sda;

  i2c_slave_regs #(
    .DEV_ID   (7'h54),
    .NUM_REGS (NumRegs),
    .FILT_LEN (4)
  ) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .i_scl     (w_scl),
    .i_sda     (w_sda),
    .o_sda_oe  (sda_oe),
    .o_wr_vld  (wr_vld),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_busy    (busy),
    .o_reg_q   (reg_q)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (wr_vld) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  // Works from idle and as a repeated START with SCL low.
  task automatic i2c_start();
    m_sda = 1'b1; q_wait();
    m_scl = 1'b1; q_wait();
    m_sda = 1'b0; q_wait();
    m_scl = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q_wait();
    m_scl = 1'b1; q_wait();
    m_sda = 1'b1; q_wait();
    q_wait();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    m_sda = b; q_wait();
    m_scl = 1'b1; q_wait();
    if (glitch) begin
      g_scl = 1'b1; @(negedge clk);
      g_scl = 1'b0; repeat (4) @(negedge clk);
      g_sda = 1'b1; @(negedge clk);
      g_sda = 1'b0;
    end
    q_wait();
    m_scl = 1'b0; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && (i == 7));
    m_sda = 1'b1; q_wait();
    m_scl = 1'b1; q_wait();
    ack = w_sda;
    q_wait();
    m_scl = 1'b0; q_wait();
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; q_wait();
      m_scl = 1'b1; q_wait();
      d[i] = w_sda;
      q_wait();
      m_scl = 1'b0; q_wait();
    end
    send_bit(mack, 1'b0);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic [2:0] exp_addr;
  } wr_vec_t;

  wr_vec_t vecs [4];

  initial begin
    logic a0, a1, a2, a3, a4;
    logic [7:0] d0, d1;
    logic [63:0] snap;
    int w0, o0, b0;
    bit found;

    vecs[0] = '{ptr: 8'h02, data: 8'h5A, exp_addr: 3'd2};
    vecs[1] = '{ptr: 8'h0C, data: 8'hC3, exp_addr: 3'd4};
    vecs[2] = '{ptr: 8'h81, data: 8'h01, exp_addr: 3'd1};
    vecs[3] = '{ptr: 8'h06, data: 8'hFF, exp_addr: 3'd6};
    for (int i = 0; i < int'(NumRegs); i++) m_regs[i] = 8'h00;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_sda_oe", {63'd0, sda_oe}, 64'd0);
    chk("rst_outputs", {wr_vld, wr_addr, wr_data, busy}, 13'd0);
    chk("rst_regs", reg_q, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single-byte writes through the pointer
    for (int v = 0; v < 4; v++) begin
      w0 = wr_cnt;
      i2c_start();
      write_byte(8'hA8, 1'b0, a0);
      write_byte(vecs[v].ptr, 1'b0, a1);
      write_byte(vecs[v].data, 1'b0, a2);
      i2c_stop();
      m_regs[vecs[v].exp_addr] = vecs[v].data;
      chk("wr_acks", {61'd0, a0, a1, a2}, 64'd0);
      chk("wr_vld_count", 64'(wr_cnt - w0), 64'd1);
      chk("wr_addr", {61'd0, last_addr}, {61'd0, vecs[v].exp_addr});
      chk("wr_data", {56'd0, last_data}, {56'd0, vecs[v].data});
      chk("wr_reg", {56'd0, reg_q[8*vecs[v].exp_addr +: 8]}, {56'd0, vecs[v].data});
      chk("wr_busy_after_stop", {63'd0, busy}, 64'd0);
    end

    // Burst write with pointer wrap, then pointer write + Sr + two-byte read
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA8, 1'b0, a0);
    write_byte(8'h07, 1'b0, a1);
    write_byte(8'h11, 1'b0, a2);
    write_byte(8'h22, 1'b0, a3);
    i2c_stop();
    m_regs[7] = 8'h11;
    m_regs[0] = 8'h22;
    chk("burst_acks", {60'd0, a0, a1, a2, a3}, 64'd0);
    chk("burst_wr_count", 64'(wr_cnt - w0), 64'd2);
    chk("burst_reg7", {56'd0, reg_q[63:56]}, 64'h11);
    chk("burst_reg0_wrap", {56'd0, reg_q[7:0]}, 64'h22);

    i2c_start();
    write_byte(8'hA8, 1'b0, a0);
    write_byte(8'h07, 1'b0, a1);
    i2c_start();
    write_byte(8'hA9, 1'b0, a2);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    repeat (Q) @(negedge clk);
    chk("rd_acks", {61'd0, a0, a1, a2}, 64'd0);
    chk("rd_byte0", {56'd0, d0}, 64'h11);
    chk("rd_byte1_wrap", {56'd0, d1}, 64'h22);
    chk("rd_nack_release", {62'd0, sda_oe, busy}, 64'd0);
    i2c_stop();

    // Address mismatch: never acknowledged, never busy, no register change
    snap = reg_q;
    o0 = oe_cnt;
    b0 = busy_cnt;
    i2c_start();
    write_byte(8'hAA, 1'b0, a0);
    write_byte(8'h01, 1'b0, a1);
    i2c_stop();
    chk("nomatch_nacks", {62'd0, a0, a1}, 64'd3);
    chk("nomatch_oe_cycles", 64'(oe_cnt - o0), 64'd0);
    chk("nomatch_busy_cycles", 64'(busy_cnt - b0), 64'd0);
    chk("nomatch_regs", reg_q, snap);

    // Short glitches on SCL and SDA during a data byte
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA8, 1'b0, a0);
    write_byte(8'h03, 1'b0, a1);
    write_byte(8'h96, 1'b1, a2);
    i2c_stop();
    m_regs[3] = 8'h96;
    chk("glitch_acks", {61'd0, a0, a1, a2}, 64'd0);
    chk("glitch_wr_count", 64'(wr_cnt - w0), 64'd1);
    chk("glitch_reg3", {56'd0, reg_q[31:24]}, 64'h96);

    // STOP after 5 bits of a data byte, then read from the retained pointer
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA8, 1'b0, a0);
    write_byte(8'h0C, 1'b0, a1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    i2c_stop();
    chk("partial_no_wr", 64'(wr_cnt - w0), 64'd0);
    chk("partial_regs", reg_q, {m_regs[7], m_regs[6], m_regs[5], m_regs[4],
                                m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    chk("partial_busy", {63'd0, busy}, 64'd0);
    i2c_start();
    write_byte(8'hA9, 1'b0, a0);
    read_byte(1'b1, d0);
    i2c_stop();
    chk("partial_read_ack", {63'd0, a0}, 64'd0);
    chk("partial_read_data", {56'd0, d0}, 64'hC3);

    // Asynchronous reset while the responder is pulling SDA low in a read
    found = 1'b0;
    i2c_start();
    write_byte(8'hA9, 1'b0, a4);
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; q_wait();
      m_scl = 1'b1; q_wait();
      if (sda_oe) begin
        found = 1'b1;
        break;
      end
      q_wait();
      m_scl = 1'b0; q_wait();
    end
    chk("rst_read_drive_seen", {63'd0, found}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_release", {63'd0, sda_oe}, 64'd0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_regs_clear", reg_q, 64'd0);
    chk("rst_busy_clear", {63'd0, busy}, 64'd0);
    i2c_start();
    write_byte(8'hA9, 1'b0, a0);
    read_byte(1'b1, d0);
    i2c_stop();
    chk("rst_read_back", {55'd0, a0, d0}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
